// File: rtl/regfile_writeback.sv
// Register-file write-port driver: merges unstallable ALU results with buffered
// load results, tracks pending loads per register and shadows x10 for the top level.
module regfile_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]           alu_data,
  input  logic                            mem_valid,
  output logic                            mem_ready,
  input  logic [ADDRESS_WIDTH-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]           mem_data,
  input  logic                            issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]        issue_rd,
  output logic [(2**ADDRESS_WIDTH)-1:0]   busy,
  output logic [ADDRESS_WIDTH-1:0]        AD3,
  output logic                            WE3,
  output logic [DATA_WIDTH-1:0]           WD3,
  output logic [DATA_WIDTH-1:0]           a0,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]         LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] A0_REG   = ADDRESS_WIDTH'(10);

  logic [ADDRESS_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;

  logic                     accept;
  logic                     fifo_empty;
  logic                     enq;
  logic                     deq;
  logic                     commit_valid;
  logic                     commit_is_load;
  logic [ADDRESS_WIDTH-1:0] commit_rd;
  logic [DATA_WIDTH-1:0]    commit_data;
  logic [NUM_REGS-1:0]      busy_next;

  // Ready depends on occupancy only; a draining full FIFO still refuses.
  assign mem_ready  = (fifo_count != FULL_CNT);
  assign accept     = mem_valid && mem_ready;
  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    commit_valid   = 1'b0;
    commit_is_load = 1'b0;
    commit_rd      = '0;
    commit_data    = '0;
    enq            = 1'b0;
    deq            = 1'b0;
    if (alu_valid) begin
      commit_valid = 1'b1;
      commit_rd    = alu_rd;
      commit_data  = alu_data;
      enq          = accept;
    end else if (!fifo_empty) begin
      commit_valid   = 1'b1;
      commit_is_load = 1'b1;
      commit_rd      = fifo_rd[rd_ptr];
      commit_data    = fifo_data[rd_ptr];
      deq            = 1'b1;
      enq            = accept;
    end else if (accept) begin
      commit_valid   = 1'b1;
      commit_is_load = 1'b1;
      commit_rd      = mem_rd;
      commit_data    = mem_data;
    end
  end

  // Set after clear so a newly issued load wins over the retiring one.
  always_comb begin
    busy_next = busy;
    if (commit_is_load) busy_next[commit_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AD3        <= '0;
      WE3        <= 1'b0;
      WD3        <= '0;
      a0         <= '0;
      busy       <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      busy <= busy_next;
      WE3  <= commit_valid && (commit_rd != '0);
      if (commit_valid && (commit_rd != '0)) begin
        AD3 <= commit_rd;
        WD3 <= commit_data;
        if (commit_rd == A0_REG) a0 <= commit_data;
      end
      if (enq) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic [4:0]  AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] a0;
  logic [1:0]  fifo_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .AD3(AD3), .WE3(WE3), .WD3(WD3), .a0(a0), .fifo_count(fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mem_valid = v; mem_rd = rd; mem_data = d;
  endtask

  task automatic iss(input logic v, input logic [4:0] rd);
    issue_valid = v; issue_rd = rd;
  endtask

  initial begin
    rst = 1'b1;
    alu(0, 0, 0); mem(0, 0, 0); iss(0, 0);
    tick(); tick();
    chk("rst_we3", WE3, 0);
    chk("rst_ad3", AD3, 0);
    chk("rst_wd3", WD3, 0);
    chk("rst_a0", a0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ready", mem_ready, 1);
    rst = 1'b0;

    // ALU only
    alu(1, 5, 32'hDEADBEEF);
    tick();
    chk("alu_ad3", AD3, 5);
    chk("alu_we3", WE3, 1);
    chk("alu_wd3", WD3, 32'hDEADBEEF);
    alu(0, 0, 0);
    tick();
    chk("alu_we3_off", WE3, 0);
    chk("alu_ad3_hold", AD3, 5);
    chk("alu_wd3_hold", WD3, 32'hDEADBEEF);
    chk("alu_a0_untouched", a0, 0);

    // Bypass with scoreboard clear
    iss(1, 7);
    tick();
    chk("byp_busy_set", busy, 32'h0000_0080);
    iss(0, 0);
    mem(1, 7, 32'h12);
    chk("byp_ready", mem_ready, 1);
    tick();
    chk("byp_we3", WE3, 1);
    chk("byp_ad3", AD3, 7);
    chk("byp_wd3", WD3, 32'h12);
    chk("byp_cnt", fifo_count, 0);
    chk("byp_busy_clr", busy, 0);
    mem(0, 0, 0);

    // Collision and backpressure
    alu(1, 1, 32'h101); mem(1, 3, 32'h33);
    tick();
    chk("col_ad3_a", AD3, 1);
    chk("col_cnt_a", fifo_count, 1);
    alu(1, 2, 32'h102); mem(1, 4, 32'h44);
    tick();
    chk("col_ad3_b", AD3, 2);
    chk("col_cnt_b", fifo_count, 2);
    chk("col_ready_full", mem_ready, 0);
    alu(1, 11, 32'h10B); mem(1, 6, 32'h66);
    tick();
    chk("col_ad3_c", AD3, 11);
    chk("col_cnt_c", fifo_count, 2);
    alu(1, 12, 32'h10C);
    tick();
    chk("col_ad3_d", AD3, 12);
    chk("col_wd3_d", WD3, 32'h10C);
    chk("col_ready_d", mem_ready, 0);
    alu(0, 0, 0);
    tick();
    chk("col_drain1_ad3", AD3, 3);
    chk("col_drain1_wd3", WD3, 32'h33);
    chk("col_drain1_we3", WE3, 1);
    chk("col_no_credit_cnt", fifo_count, 1);
    tick();
    chk("col_drain2_ad3", AD3, 4);
    chk("col_drain2_wd3", WD3, 32'h44);
    chk("col_enq6_cnt", fifo_count, 1);
    mem(0, 0, 0);
    tick();
    chk("col_drain3_ad3", AD3, 6);
    chk("col_drain3_wd3", WD3, 32'h66);
    chk("col_drain3_we3", WE3, 1);
    chk("col_empty", fifo_count, 0);
    tick();
    chk("col_idle_we3", WE3, 0);

    // x0 handling
    iss(1, 0);
    tick();
    chk("x0_busy_never_set", busy, 0);
    iss(0, 0);
    alu(1, 1, 32'h1); mem(1, 0, 32'h55);
    tick();
    chk("x0_enq_cnt", fifo_count, 1);
    chk("x0_alu_ad3", AD3, 1);
    alu(0, 0, 0); mem(0, 0, 0);
    tick();
    chk("x0_we3", WE3, 0);
    chk("x0_consumed", fifo_count, 0);
    chk("x0_busy", busy, 0);
    chk("x0_ad3_hold", AD3, 1);

    // Set wins over same-cycle clear
    iss(1, 9);
    tick();
    chk("sw_busy_set", busy, 32'h0000_0200);
    mem(1, 9, 32'h99);
    tick();
    chk("sw_we3", WE3, 1);
    chk("sw_ad3", AD3, 9);
    chk("sw_busy_kept", busy, 32'h0000_0200);
    iss(0, 0); mem(1, 9, 32'h98);
    tick();
    chk("sw_clear", busy, 0);
    chk("sw_wd3", WD3, 32'h98);
    mem(0, 0, 0);

    // a0 shadow and reset mid-operation
    alu(1, 10, 32'hA0);
    tick();
    chk("a0_val", a0, 32'hA0);
    chk("a0_we3", WE3, 1);
    alu(1, 1, 32'h201); mem(1, 3, 32'h301); iss(1, 13);
    tick();
    chk("fill_cnt1", fifo_count, 1);
    chk("fill_busy", busy, 32'h0000_2000);
    iss(0, 0);
    alu(1, 2, 32'h202); mem(1, 4, 32'h302);
    tick();
    chk("fill_cnt2", fifo_count, 2);
    alu(0, 0, 0); mem(1, 6, 32'h303); iss(1, 8);
    rst = 1'b1;
    tick();
    chk("mid_rst_a0", a0, 0);
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we3", WE3, 0);
    chk("mid_rst_ready", mem_ready, 1);
    chk("mid_rst_ad3", AD3, 0);
    rst = 1'b0;
    mem(0, 0, 0); iss(0, 0);
    tick();
    chk("post_rst_we3_a", WE3, 0);
    tick();
    chk("post_rst_we3_b", WE3, 0);
    chk("post_rst_cnt", fifo_count, 0);
    chk("post_rst_wd3", WD3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
